// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared types, defaults and helpers for the multiplier arbiter
//
// Purpose: FSM state encoding, default NUM_REQ/OP_W and the index-width helper
// used by mult_arbiter, mult_arbiter_if and rr_picker.
// Ports: none (package).
package mult_arb_pkg;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_OP_W    = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_START   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_RELEASE = 2'd3
   } arb_state_t;

   // Width of an index into n entries; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// rtl/mult_arbiter_if.sv - requester and multiplier signal bundle for mult_arbiter
//
// Purpose: groups the requester-side and multiplier-side signals of the arbiter.
// Ports (signals):
//   Req, Multiplicando_In, Multiplicador_In          requester -> arbiter
//   Ack, Produto_Out, Err, Grant_Id, Busy            arbiter -> requesters
//   Mul_Multiplicando, Mul_Multiplicador, Mul_St     arbiter -> multiplier
//   Mul_Done, Mul_Idle, Mul_Produto                  multiplier -> arbiter
// Modports: slave = arbiter view, master = environment view.
interface mult_arbiter_if
   import mult_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int OP_W    = DEF_OP_W
) ();

   localparam int IW = idx_w(NUM_REQ);

   logic [NUM_REQ-1:0]      Req;
   logic [NUM_REQ*OP_W-1:0] Multiplicando_In;
   logic [NUM_REQ*OP_W-1:0] Multiplicador_In;
   logic [NUM_REQ-1:0]      Ack;
   logic [2*OP_W-1:0]       Produto_Out;
   logic                    Err;
   logic [IW-1:0]           Grant_Id;
   logic                    Busy;
   logic [OP_W-1:0]         Mul_Multiplicando;
   logic [OP_W-1:0]         Mul_Multiplicador;
   logic                    Mul_St;
   logic                    Mul_Done;
   logic                    Mul_Idle;
   logic [2*OP_W-1:0]       Mul_Produto;

   modport slave (
      input  Req, Multiplicando_In, Multiplicador_In,
      input  Mul_Done, Mul_Idle, Mul_Produto,
      output Ack, Produto_Out, Err, Grant_Id, Busy,
      output Mul_Multiplicando, Mul_Multiplicador, Mul_St
   );

   modport master (
      output Req, Multiplicando_In, Multiplicador_In,
      output Mul_Done, Mul_Idle, Mul_Produto,
      input  Ack, Produto_Out, Err, Grant_Id, Busy,
      input  Mul_Multiplicando, Mul_Multiplicador, Mul_St
   );

endinterface

// File: rtl/mult_arbiter_rr_picker.sv
// rtl/mult_arbiter_rr_picker.sv - combinational round-robin priority picker
//
// Purpose: picks the first set request bit searching upward from ptr_i+1 with
// wrap-around; the entry at ptr_i itself has the lowest priority.
// Ports:
//   req_i    in  NUM_REQ  request vector
//   ptr_i    in  IW       index of the last winner
//   gnt_o    out IW       index of the winner (0 when none)
//   valid_o  out 1        at least one request set
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IW      = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic [IW-1:0]      gnt_o,
   output logic               valid_o
);

   int  idx;
   logic found;

   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = int'(ptr_i) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!found && req_i[idx]) begin
            gnt_o = IW'(idx);
            found = 1'b1;
         end
      end
   end

   assign valid_o = found;

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one shift-add multiplier
//
// Purpose: arbitrates NUM_REQ requesters onto one sequential multiplier, latches
// the winner's operands, pulses Mul_St, waits for Mul_Done and returns the
// product with a one-cycle one-hot Ack.
// Optional feature: define MULT_TIMEOUT_EN to enable a WAIT-state watchdog of
// TIMEOUT_CYC cycles that completes the operation with Err=1 and a zero product.
// Ports:
//   Clk     in   clock, rising edge
//   Rst_n   in   asynchronous active-low reset
//   arb_if  slave modport of mult_arbiter_if (requester and multiplier sides)
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int NUM_REQ     = DEF_NUM_REQ,
   parameter int OP_W        = DEF_OP_W,
   parameter int TIMEOUT_CYC = 32
) (
   input  logic          Clk,
   input  logic          Rst_n,
   mult_arbiter_if.slave arb_if
);

   localparam int IW = idx_w(NUM_REQ);
   localparam int PW = 2 * OP_W;

   arb_state_t          state_q, state_d;
   logic [IW-1:0]       ptr_q, ptr_d;
   logic [IW-1:0]       grant_q, grant_d;
   logic [OP_W-1:0]     mcand_q, mcand_d;
   logic [OP_W-1:0]     mplier_q, mplier_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   logic [PW-1:0]       prod_q, prod_d;
   logic                st_q, st_d;
   logic                timeout_hit;

   logic [IW-1:0]       pick_idx;
   logic                pick_vld;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_picker (
      .req_i   (arb_if.Req),
      .ptr_i   (ptr_q),
      .gnt_o   (pick_idx),
      .valid_o (pick_vld)
   );

`ifdef MULT_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] cnt_q;
   logic          err_q;

   // Counter is held at 0 outside WAIT, so it reads 0 in the first WAIT cycle
   // and saturates at TIMEOUT_CYC.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt_q <= '0;
      end else if (state_q != ST_WAIT) begin
         cnt_q <= '0;
      end else if (cnt_q != CW'(TIMEOUT_CYC)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign timeout_hit = (state_q == ST_WAIT) && (cnt_q == CW'(TIMEOUT_CYC));

   // Err is only rewritten when an Ack is issued; a real Done wins over timeout.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         err_q <= 1'b0;
      end else if ((state_q == ST_WAIT) && (arb_if.Mul_Done || timeout_hit)) begin
         err_q <= !arb_if.Mul_Done;
      end
   end

   assign arb_if.Err = err_q;
`else
   assign timeout_hit = 1'b0;
   assign arb_if.Err  = 1'b0;
`endif

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q  <= ST_IDLE;
         ptr_q    <= IW'(NUM_REQ - 1);
         grant_q  <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         ack_q    <= '0;
         prod_q   <= '0;
         st_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         ack_q    <= ack_d;
         prod_q   <= prod_d;
         st_q     <= st_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      ack_d    = '0;
      prod_d   = prod_q;
      st_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Mul_Idle guards against a multiplier still busy from before our reset.
            if (pick_vld && arb_if.Mul_Idle) begin
               grant_d  = pick_idx;
               ptr_d    = pick_idx;
               mcand_d  = arb_if.Multiplicando_In[int'(pick_idx)*OP_W +: OP_W];
               mplier_d = arb_if.Multiplicador_In[int'(pick_idx)*OP_W +: OP_W];
               st_d     = 1'b1;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (arb_if.Mul_Done) begin
               prod_d  = arb_if.Mul_Produto;
               ack_d   = NUM_REQ'(1) << grant_q;
               state_d = ST_RELEASE;
            end else if (timeout_hit) begin
               prod_d  = '0;
               ack_d   = NUM_REQ'(1) << grant_q;
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign arb_if.Ack               = ack_q;
   assign arb_if.Produto_Out       = prod_q;
   assign arb_if.Grant_Id          = grant_q;
   assign arb_if.Busy              = (state_q != ST_IDLE);
   assign arb_if.Mul_Multiplicando = mcand_q;
   assign arb_if.Mul_Multiplicador = mplier_q;
   assign arb_if.Mul_St            = st_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - directed vector bench for mult_arbiter
module tb_mult_arbiter;
   import mult_arb_pkg::*;

   localparam int NUM_REQ     = 4;
   localparam int OP_W        = 4;
   localparam int TIMEOUT_CYC = 32;
   localparam int MUL_LAT     = 9;

   logic Clk   = 1'b0;
   logic Rst_n = 1'b0;
   always #5 Clk = ~Clk;

   mult_arbiter_if #(.NUM_REQ(NUM_REQ), .OP_W(OP_W)) bus ();

   mult_arbiter #(
      .NUM_REQ     (NUM_REQ),
      .OP_W        (OP_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .Clk    (Clk),
      .Rst_n  (Rst_n),
      .arb_if (bus)
   );

   // Multiplier model: no reset, Done one cycle after counting down, product of
   // the operands seen with St.
   logic       m_busy    = 1'b0;
   int         m_cnt     = 0;
   logic [7:0] m_prod    = 8'd0;
   logic [3:0] m_a       = 4'd0;
   logic [3:0] m_b       = 4'd0;
   logic       done_en   = 1'b1;
   logic       idle_hold = 1'b0;

   assign bus.Mul_Done    = m_busy && (m_cnt == 0) && done_en;
   assign bus.Mul_Idle    = !m_busy && !idle_hold;
   assign bus.Mul_Produto = m_prod;

   always @(posedge Clk) begin
      if (!m_busy) begin
         if (bus.Mul_St) begin
            m_busy <= 1'b1;
            m_cnt  <= MUL_LAT;
            m_a    <= bus.Mul_Multiplicando;
            m_b    <= bus.Mul_Multiplicador;
            m_prod <= {4'd0, bus.Mul_Multiplicando} * {4'd0, bus.Mul_Multiplicador};
         end
      end else if (m_cnt != 0) begin
         m_cnt <= m_cnt - 1;
      end else if (done_en) begin
         m_busy <= 1'b0;
      end
   end

   int st_cnt  = 0;
   int ack_cnt = 0;
   int op_bad  = 0;
   always @(posedge Clk) begin
      if (bus.Mul_St) st_cnt <= st_cnt + 1;
      if (bus.Ack != '0) ack_cnt <= ack_cnt + 1;
      if (m_busy && ((bus.Mul_Multiplicando != m_a) || (bus.Mul_Multiplicador != m_b)))
         op_bad <= op_bad + 1;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply_reset();
      Rst_n   = 1'b0;
      bus.Req = '0;
      repeat (2) @(negedge Clk);
      Rst_n = 1'b1;
   endtask

   task automatic wait_ack(input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge Clk);
         if (bus.Ack != '0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_st(input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge Clk);
         if (bus.Mul_St) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   typedef struct {
      bit          rst;
      logic [3:0]  req;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  exp_ack;
      logic [1:0]  exp_gid;
      logic [7:0]  exp_prod;
   } vec_t;

   localparam int NV = 9;
   vec_t vecs [NV];

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      bit ok;
      int st0, ob0, ack0, n;

      vecs[0] = '{1'b1, 4'b0001, 16'h0003, 16'h0005, 4'b0001, 2'd0, 8'd15};
      vecs[1] = '{1'b1, 4'b1111, 16'hF642, 16'hF753, 4'b0001, 2'd0, 8'd6};
      vecs[2] = '{1'b0, 4'b1110, 16'hF642, 16'hF753, 4'b0010, 2'd1, 8'd20};
      vecs[3] = '{1'b0, 4'b1100, 16'hF642, 16'hF753, 4'b0100, 2'd2, 8'd42};
      vecs[4] = '{1'b0, 4'b1000, 16'hF642, 16'hF753, 4'b1000, 2'd3, 8'd225};
      vecs[5] = '{1'b0, 4'b0101, 16'hF642, 16'hF753, 4'b0001, 2'd0, 8'd6};
      vecs[6] = '{1'b0, 4'b0101, 16'hF642, 16'hF753, 4'b0100, 2'd2, 8'd42};
      vecs[7] = '{1'b0, 4'b0101, 16'hF642, 16'hF753, 4'b0001, 2'd0, 8'd6};
      vecs[8] = '{1'b0, 4'b0101, 16'hF642, 16'hF753, 4'b0100, 2'd2, 8'd42};

      bus.Req              = '0;
      bus.Multiplicando_In = '0;
      bus.Multiplicador_In = '0;

      // Reset state.
      @(negedge Clk);
      chk("rst_ack",   32'(bus.Ack), 0);
      chk("rst_prod",  32'(bus.Produto_Out), 0);
      chk("rst_err",   32'(bus.Err), 0);
      chk("rst_gid",   32'(bus.Grant_Id), 0);
      chk("rst_busy",  32'(bus.Busy), 0);
      chk("rst_st",    32'(bus.Mul_St), 0);
      chk("rst_mcand", 32'(bus.Mul_Multiplicando), 0);
      chk("rst_mplr",  32'(bus.Mul_Multiplicador), 0);

      // Vector table.
      for (int i = 0; i < NV; i++) begin
         if (vecs[i].rst) apply_reset();
         bus.Req              = vecs[i].req;
         bus.Multiplicando_In = vecs[i].a;
         bus.Multiplicador_In = vecs[i].b;
         st0 = st_cnt;
         ob0 = op_bad;
         wait_ack(100, ok);
         chk($sformatf("v%0d_ack_seen", i), 32'(ok), 1);
         chk($sformatf("v%0d_ack", i),  32'(bus.Ack), 32'(vecs[i].exp_ack));
         chk($sformatf("v%0d_gid", i),  32'(bus.Grant_Id), 32'(vecs[i].exp_gid));
         chk($sformatf("v%0d_prod", i), 32'(bus.Produto_Out), 32'(vecs[i].exp_prod));
         chk($sformatf("v%0d_err", i),  32'(bus.Err), 0);
         chk($sformatf("v%0d_st_pulses", i), 32'(st_cnt - st0), 1);
         chk($sformatf("v%0d_op_stable", i), 32'(op_bad - ob0), 0);
         if (i == NV - 1 || vecs[i+1].rst) begin
            bus.Req = '0;
            @(negedge Clk);
            chk($sformatf("v%0d_ack_one_cycle", i), 32'(bus.Ack), 0);
            chk($sformatf("v%0d_idle_after", i), 32'(bus.Busy), 0);
            chk($sformatf("v%0d_prod_held", i), 32'(bus.Produto_Out), 32'(vecs[i].exp_prod));
         end
      end

      // Multiplier not idle after reset: no start until Mul_Idle rises.
      idle_hold = 1'b1;
      apply_reset();
      bus.Multiplicando_In = 16'hF642;
      bus.Multiplicador_In = 16'hF753;
      bus.Req = 4'b0010;
      st0 = st_cnt;
      repeat (20) @(negedge Clk);
      chk("idle_hold_no_st", 32'(st_cnt - st0), 0);
      chk("idle_hold_busy",  32'(bus.Busy), 0);
      idle_hold = 1'b0;
      wait_ack(100, ok);
      chk("idle_ack_seen", 32'(ok), 1);
      chk("idle_ack",      32'(bus.Ack), 32'b0010);
      chk("idle_prod",     32'(bus.Produto_Out), 20);
      chk("idle_st_once",  32'(st_cnt - st0), 1);
      bus.Req = '0;
      @(negedge Clk);

      // Reset pulsed during WAIT.
      bus.Req = 4'b0100;
      wait_st(20, ok);
      chk("abort_st_seen", 32'(ok), 1);
      repeat (3) @(negedge Clk);
      chk("abort_busy_before", 32'(bus.Busy), 1);
      ack0 = ack_cnt;
      #2;
      Rst_n = 1'b0;
      #1;
      chk("abort_busy",  32'(bus.Busy), 0);
      chk("abort_ack",   32'(bus.Ack), 0);
      chk("abort_gid",   32'(bus.Grant_Id), 0);
      chk("abort_prod",  32'(bus.Produto_Out), 0);
      chk("abort_mcand", 32'(bus.Mul_Multiplicando), 0);
      chk("abort_st",    32'(bus.Mul_St), 0);
      @(negedge Clk);
      bus.Req = 4'b1010;
      @(negedge Clk);
      Rst_n = 1'b1;
      wait_ack(100, ok);
      chk("post_abort_ack_seen", 32'(ok), 1);
      chk("post_abort_no_stale", 32'(ack_cnt - ack0), 0);
      chk("post_abort_ack",      32'(bus.Ack), 32'b0010);
      chk("post_abort_gid",      32'(bus.Grant_Id), 1);
      chk("post_abort_prod",     32'(bus.Produto_Out), 20);
      bus.Req = '0;
      @(negedge Clk);

      // Multiplier never signals Done.
      done_en = 1'b0;
      bus.Req = 4'b0001;
      wait_st(20, ok);
      chk("to_st_seen", 32'(ok), 1);
`ifdef MULT_TIMEOUT_EN
      n = 0;
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge Clk);
         n++;
         if (bus.Ack != '0) begin
            ok = 1'b1;
            break;
         end
      end
      chk("to_ack_seen", 32'(ok), 1);
      chk("to_latency",  32'(n), 32'(TIMEOUT_CYC + 2));
      chk("to_ack",      32'(bus.Ack), 32'b0001);
      chk("to_err",      32'(bus.Err), 1);
      chk("to_prod",     32'(bus.Produto_Out), 0);
      bus.Req = '0;
      @(negedge Clk);
      chk("to_ack_one_cycle", 32'(bus.Ack), 0);
`else
      ack0 = ack_cnt;
      n = 0;
      repeat (60) @(negedge Clk);
      chk("nto_busy",   32'(bus.Busy), 1);
      chk("nto_no_ack", 32'(ack_cnt - ack0), 0);
      chk("nto_err",    32'(bus.Err), 0);
      chk("nto_n",      32'(n), 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one sequential shift-add multiplier between NUM_REQ requesters.
- Arbitrates round-robin and latches the winner's operands.
- Issues the one-cycle start pulse, waits for the multiplier's done, and returns the product with a one-cycle ack.
- Sits between the requesting blocks and the multiplier's St/Done/Idle/operand/product interface.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- OP_W, 4: operand width; product width is 2*OP_W.
- TIMEOUT_CYC, 32: WAIT-state watchdog limit; used only with MULT_TIMEOUT_EN.

Ports:
- Clk  in  1  clock, all state on rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Req  in  NUM_REQ  per-requester request level; held until matching Ack.
- Multiplicando_In  in  NUM_REQ*OP_W  flattened operands; slice i belongs to requester i.
- Multiplicador_In  in  NUM_REQ*OP_W  flattened operands; slice i belongs to requester i.
- Ack  out  NUM_REQ  one-hot, one-cycle completion pulse.
- Produto_Out  out  2*OP_W  result; valid in the Ack cycle and held until the next Ack.
- Err  out  1  timeout flag, valid with Ack.
- Grant_Id  out  clog2(NUM_REQ)  index of the current or last grantee.
- Busy  out  1  high when the FSM is not in IDLE.
- Mul_Multiplicando  out  OP_W  operand to the multiplier.
- Mul_Multiplicador  out  OP_W  operand to the multiplier.
- Mul_St  out  1  start pulse to the multiplier.
- Mul_Done  in  1  multiplier done.
- Mul_Idle  in  1  multiplier idle.
- Mul_Produto  in  2*OP_W  multiplier product.

Behaviour:
- Reset values (all registered outputs):
  - Ack=0, Produto_Out=0, Err=0, Grant_Id=0, Busy=0, Mul_St=0.
  - Operand registers = 0; state = IDLE; RR pointer = NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, START, WAIT, RELEASE.
- IDLE:
  - Arbitrate only when Req != 0 AND Mul_Idle=1.
  - Winner = first set Req bit, searching from pointer+1 upward with wrap-around.
  - Latch the winner's operand slices into Mul_Multiplicando/Mul_Multiplicador; update Grant_Id and pointer; go to START.
  - If Mul_Idle=0, stay in IDLE. This covers the multiplier, which has no reset, still finishing an operation after our reset.
- START: Mul_St=1 for exactly this cycle; go to WAIT.
- WAIT:
  - Operands are held stable; the multiplier reads them every cycle.
  - On the edge where Mul_Done=1 is sampled, register Mul_Produto into Produto_Out and set Ack[Grant_Id]=1 for the next cycle; go to RELEASE.
- RELEASE:
  - Ack is high this cycle only.
  - The requester must drop Req by this edge; Req still high after RELEASE is treated as a new request.
  - Go to IDLE.
- Latency: Req sampled in IDLE at cycle t → Mul_St at t+1 → WAIT from t+2 → Mul_Done sampled at d → Ack at d+1. Minimum issue-to-issue gap is 4 cycles plus multiplier time.
- Req dropped after grant: the operation completes and Ack still pulses; the result is discarded by the requester.
- Req changes during WAIT: ignored; arbitration happens only in IDLE.
- Mul_Done outside WAIT: ignored.
- Rst_n low mid-operation: immediate return to reset values; no Ack for the aborted operation.
- Arithmetic: none in the arbiter. Pointer increments modulo NUM_REQ.

Optional Feature:
- Macro: MULT_TIMEOUT_EN.
- Defined:
  - A WAIT cycle counter starts at 0 on WAIT entry.
  - If it reaches TIMEOUT_CYC without Mul_Done, the next cycle gives Ack[Grant_Id]=1, Err=1, Produto_Out=0, then RELEASE.
  - Err clears on the next Ack, or stays 0 for a normal completion.
- Undefined: no counter; Err tied to 0; WAIT waits indefinitely.

Decomposition:
- Package mult_arb_pkg holds:
  - the state encoding constants (IDLE, START, WAIT, RELEASE);
  - the default OP_W/NUM_REQ;
  - the index-width function.
- Sub-module rr_picker: combinational round-robin priority picker with inputs Req and pointer, outputs grant index and a valid flag. It is reused by other shared-resource arbiters.

Test Plan:
- Reset then Req=0001, operands 3×5; model Done 10 cycles after St → exactly one Mul_St pulse, operands held 3/5 through WAIT, Ack=0001, Produto_Out=15, Err=0.
- Req=1111 simultaneously with operands (2,3),(4,5),(6,7),(15,15) → grant order 0,1,2,3; products 6,20,42,225; each Ack one cycle.
- Req0 and Req2 re-asserted immediately after every Ack → grants alternate 0,2,0,2; requesters 1 and 3 never acked.
- Mul_Idle held 0 for 20 cycles after reset with Req=0010 → no Mul_St until Mul_Idle=1, then one Mul_St.
- Rst_n pulsed low during WAIT → all outputs at reset values asynchronously; no Ack; next grant goes to the lowest requesting index.
- With MULT_TIMEOUT_EN, Mul_Done never asserted → Ack at cycle TIMEOUT_CYC+1 after WAIT entry with Err=1 and Produto_Out=0; without the macro, Busy stays 1 and there is no Ack.
